// File: rtl/graphics_processor.sv
// graphics_processor: rectangle fill / image-ROM copy engine writing a 12-bit framebuffer
// in raster order at one pixel per cycle.
module graphics_processor #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        opcode,
    input  logic [9:0]  tl_x,
    input  logic [8:0]  tl_y,
    input  logic [9:0]  br_x,
    input  logic [8:0]  br_y,
    input  logic [11:0] arg,
    output logic        finish,
    output logic        vram_we,
    output logic [18:0] vram_addr,
    output logic [11:0] vram_din,
    output logic [18:0] img_addr,
    input  logic [11:0] img_data
);
    typedef enum logic [1:0] {IDLE, FILL, COPY, DONE} state_t;
    localparam logic [18:0] HR = 19'(H_RES);

    state_t      state_q;
    logic [9:0]  tl_x_q, br_x_q, x_q;
    logic [8:0]  br_y_q, y_q;
    logic [18:0] row_q, vram_addr_q, img_addr_q;
    logic [11:0] din_q;
    logic        we_q, copy_wr_q, rd_done_q, finish_q;

    logic [9:0]  bx_c;
    logic [8:0]  by_c;
    logic [18:0] base_c, start_c, cur_c, nxt_c;
    logic        empty_c, eol_c, last_c, adv_c;

    // Start row base as a constant shift-add of tl_y; later rows step by H_RES.
    always_comb begin
        base_c = '0;
        for (int b = 0; b < 19; b++)
            if (HR[b]) base_c = base_c + (19'(tl_y) << b);
    end

    assign bx_c    = (br_x > 10'(H_RES - 1)) ? 10'(H_RES - 1) : br_x;
    assign by_c    = (br_y > 9'(V_RES - 1)) ? 9'(V_RES - 1) : br_y;
    assign start_c = base_c + 19'(tl_x);
    assign empty_c = (tl_x > bx_c) || (tl_y > by_c);
    assign eol_c   = x_q == br_x_q;
    assign last_c  = eol_c && (y_q == br_y_q);
    assign cur_c   = (state_q == COPY) ? img_addr_q : vram_addr_q;
    assign nxt_c   = eol_c ? row_q + HR + 19'(tl_x_q) : cur_c + 19'd1;
    assign adv_c   = !last_c && (state_q == FILL || (state_q == COPY && !rd_done_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tl_x_q      <= '0;
            br_x_q      <= '0;
            br_y_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            row_q       <= '0;
            vram_addr_q <= '0;
            img_addr_q  <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            copy_wr_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (en) begin
                    tl_x_q    <= tl_x;
                    br_x_q    <= bx_c;
                    br_y_q    <= by_c;
                    x_q       <= tl_x;
                    y_q       <= tl_y;
                    row_q     <= base_c;
                    rd_done_q <= 1'b0;
                    if (empty_c) begin
                        state_q  <= DONE;
                        finish_q <= 1'b1;
                    end else if (opcode) begin
                        state_q    <= COPY;
                        img_addr_q <= start_c;
                    end else begin
                        state_q     <= FILL;
                        we_q        <= 1'b1;
                        vram_addr_q <= start_c;
                        din_q       <= arg;
                    end
                end
                FILL: if (last_c) begin
                    we_q     <= 1'b0;
                    state_q  <= DONE;
                    finish_q <= 1'b1;
                end else begin
                    vram_addr_q <= nxt_c;
                end
                COPY: begin
                    // Keep the last ROM word so vram_din holds once writing stops.
                    if (copy_wr_q) din_q <= img_data;
                    if (rd_done_q) begin
                        we_q      <= 1'b0;
                        copy_wr_q <= 1'b0;
                        state_q   <= DONE;
                        finish_q  <= 1'b1;
                    end else begin
                        we_q        <= 1'b1;
                        copy_wr_q   <= 1'b1;
                        vram_addr_q <= img_addr_q;
                        if (last_c) rd_done_q <= 1'b1;
                        else img_addr_q <= nxt_c;
                    end
                end
                DONE: if (!en) begin
                    state_q  <= IDLE;
                    finish_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            if (adv_c) begin
                x_q   <= eol_c ? tl_x_q : x_q + 10'd1;
                y_q   <= eol_c ? y_q + 9'd1 : y_q;
                row_q <= eol_c ? row_q + HR : row_q;
            end
        end
    end

    assign finish    = finish_q;
    assign vram_we   = we_q;
    assign vram_addr = vram_addr_q;
    assign img_addr  = img_addr_q;
    assign vram_din  = copy_wr_q ? img_data : din_q;
endmodule

// File: tb/tb_graphics_processor.sv
// tb_graphics_processor: scenario tasks plus a write scoreboard fed by a rectangle model
// and drained by a negedge monitor on the framebuffer port.
module tb_graphics_processor;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, opcode = 1'b0;
    logic [9:0]  tl_x = '0, br_x = '0;
    logic [8:0]  tl_y = '0, br_y = '0;
    logic [11:0] arg = '0, img_data = '0;
    logic        finish, vram_we;
    logic [18:0] vram_addr, img_addr;
    logic [11:0] vram_din;

    typedef struct {logic [18:0] a; logic [11:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0, failures = 0, writes_n = 0;

    graphics_processor dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode),
        .tl_x(tl_x), .tl_y(tl_y), .br_x(br_x), .br_y(br_y), .arg(arg),
        .finish(finish), .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
        .img_addr(img_addr), .img_data(img_data)
    );

    always #5 clk = ~clk;

    // Synchronous ROM whose word is the low 12 address bits.
    always @(posedge clk) img_data <= img_addr[11:0];

    always @(negedge clk) if (!rst && vram_we) begin
        writes_n++;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write got addr=%0d din=%h, expected no write", vram_addr, vram_din);
        end else begin
            mon_e = exp_q.pop_front();
            if (vram_addr !== mon_e.a || vram_din !== mon_e.d) begin
                failures++;
                $display("FAIL write got addr=%0d din=%h expected addr=%0d din=%h",
                         vram_addr, vram_din, mon_e.a, mon_e.d);
            end
        end
    end

    task automatic push_rect(input logic op, input int tx, ty, bx, by, input logic [11:0] c);
        int ex = bx > 639 ? 639 : bx;
        int ey = by > 479 ? 479 : by;
        for (int y = ty; y <= ey; y++)
            for (int x = tx; x <= ex; x++) begin
                int a = y * 640 + x;
                exp_q.push_back('{19'(a), op ? 12'(a) : c});
            end
    endtask

    task automatic issue(input logic op, input int tx, ty, bx, by, input logic [11:0] c);
        @(negedge clk);
        opcode = op; tl_x = 10'(tx); tl_y = 9'(ty); br_x = 10'(bx); br_y = 9'(by); arg = c;
        en = 1'b1;
        push_rect(op, tx, ty, bx, by, c);
    endtask

    task automatic wait_finish(input int budget, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (finish) break;
            if (n >= budget) begin n = -1; break; end
        end
    endtask

    task automatic drop_en();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({vram_we, finish, vram_addr, img_addr, vram_din} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got we=%b fin=%b addr=%0d img=%0d din=%h expected all zero",
                     vram_we, finish, vram_addr, img_addr, vram_din);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill_small();
        int n, w0 = writes_n;
        issue(1'b0, 1, 1, 2, 2, 12'hFFF);
        wait_finish(50, n);
        checks++;
        if (n !== 5 || writes_n - w0 !== 4) begin
            failures++;
            $display("FAIL fill_small got finish_cycle=%0d writes=%0d expected 5 and 4", n, writes_n - w0);
        end
        drop_en();
        checks++;
        if (finish !== 1'b0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL fill_small_release got finish=%b pending=%0d expected 0 and 0", finish, exp_q.size());
        end
    endtask

    task automatic test_copy();
        int n;
        issue(1'b1, 0, 0, 1, 0, 12'h000);
        @(negedge clk);
        checks++;
        if (img_addr !== 19'd0 || vram_we !== 1'b0) begin
            failures++;
            $display("FAIL copy_c1 got img_addr=%0d we=%b expected 0 and 0", img_addr, vram_we);
        end
        @(negedge clk);
        checks++;
        if (img_addr !== 19'd1 || vram_we !== 1'b1) begin
            failures++;
            $display("FAIL copy_c2 got img_addr=%0d we=%b expected 1 and 1", img_addr, vram_we);
        end
        wait_finish(20, n);
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL copy_finish got cycles=%0d expected 2", n);
        end
        drop_en();
        checks++;
        if (finish !== 1'b0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL copy_release got finish=%b pending=%0d expected 0 and 0", finish, exp_q.size());
        end
    endtask

    task automatic test_empty();
        int n, w0 = writes_n;
        issue(1'b0, 5, 0, 4, 0, 12'h123);
        wait_finish(20, n);
        checks++;
        if (n !== 1 || writes_n !== w0) begin
            failures++;
            $display("FAIL empty got finish_cycle=%0d writes=%0d expected 1 and 0", n, writes_n - w0);
        end
        drop_en();
    endtask

    task automatic test_clamp();
        int n, w0 = writes_n;
        issue(1'b0, 630, 479, 700, 500, 12'hABC);
        wait_finish(50, n);
        checks++;
        if (n !== 11 || writes_n - w0 !== 10 || vram_addr !== 19'd307199) begin
            failures++;
            $display("FAIL clamp got finish_cycle=%0d writes=%0d held_addr=%0d expected 11, 10, 307199",
                     n, writes_n - w0, vram_addr);
        end
        drop_en();
    endtask

    task automatic test_rst_mid();
        int n, w0 = writes_n, k = 0;
        issue(1'b0, 10, 10, 19, 19, 12'h123);
        while (writes_n - w0 < 3 && k < 20) begin
            @(negedge clk);
            #1 k++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (vram_we !== 1'b0 || finish !== 1'b0 || k >= 20) begin
            failures++;
            $display("FAIL rst_mid_async got we=%b finish=%b wait=%0d expected 0, 0, <20", vram_we, finish, k);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        w0 = writes_n;
        push_rect(1'b0, 10, 10, 19, 19, 12'h123);
        wait_finish(300, n);
        checks++;
        if (n !== 101 || writes_n - w0 !== 100) begin
            failures++;
            $display("FAIL rst_mid_restart got finish_cycle=%0d writes=%0d expected 101 and 100", n, writes_n - w0);
        end
        drop_en();
    endtask

    task automatic test_en_drop();
        int n, w0 = writes_n;
        issue(1'b0, 0, 5, 3, 5, 12'h5A5);
        @(negedge clk);
        en = 1'b0;
        wait_finish(20, n);
        checks++;
        if (n !== 4 || writes_n - w0 !== 4) begin
            failures++;
            $display("FAIL en_drop got finish_cycle=%0d writes=%0d expected 4 and 4", n, writes_n - w0);
        end
        @(negedge clk);
        checks++;
        if (finish !== 1'b0) begin
            failures++;
            $display("FAIL en_drop_pulse got finish=%b expected 0", finish);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (vram_we !== 1'b0 || finish !== 1'b0 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL en_drop_idle got we=%b finish=%b pending=%0d expected 0, 0, 0",
                     vram_we, finish, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            int n, w, h, tx, ty;
            logic op = 1'($urandom_range(0, 1));
            w  = $urandom_range(1, 4);
            h  = $urandom_range(1, 3);
            tx = $urandom_range(0, 600);
            ty = $urandom_range(0, 470);
            issue(op, tx, ty, tx + w - 1, ty + h - 1, 12'($urandom));
            wait_finish(50, n);
            checks++;
            if (n !== w * h + (op ? 2 : 1)) begin
                failures++;
                $display("FAIL b2b_%0d got finish_cycle=%0d expected %0d", i, n, w * h + (op ? 2 : 1));
            end
            drop_en();
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL b2b_pending got %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill_small();
        test_copy();
        test_empty();
        test_clamp();
        test_rst_mid();
        test_en_drop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/graphics_processor.md
GRAPHICS_PROCESSOR -- requirements
Module: graphics_processor

Interface
REQ-001 Parameter H_RES, 640, framebuffer width in pixels.
REQ-002 Parameter V_RES, 480, framebuffer height in pixels.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port en  in  1  command request, held high by the requester until finish is seen.
REQ-006 Port opcode  in  1  0 = solid fill with arg, 1 = copy from image ROM.
REQ-007 Ports tl_x/br_x  in  10 each; tl_y/br_y  in  9 each: rectangle corners, inclusive.
REQ-008 Port arg  in  12  fill colour, 4 bits per channel.
REQ-009 Port finish  out  1  command complete.
REQ-010 Ports vram_we  out  1; vram_addr  out  19; vram_din  out  12: framebuffer write port.
REQ-011 Port img_addr  out  19  image ROM read address; img_data  in  12  ROM data, valid one cycle after img_addr.

Function
REQ-012 States SHALL be IDLE, FILL, COPY, DONE.
REQ-013 IDLE: when en=1 at a clock edge, opcode/arg/corners SHALL be latched; the next state is FILL (opcode 0) or COPY (opcode 1); inputs are ignored until the next return to IDLE.
REQ-014 Latched br_x SHALL be clamped to H_RES-1 and br_y to V_RES-1.
REQ-015 If tl_x > clamped br_x or tl_y > clamped br_y, the next state SHALL be DONE with zero writes.
REQ-016 Pixel address SHALL be y*H_RES + x, formed incrementally (row base += H_RES per row); no multiplier.
REQ-017 Pixels SHALL be visited in raster order: x from tl_x to br_x, then y+1, ending at (br_x, br_y).
REQ-018 FILL: one write per cycle, vram_we=1, vram_din=arg; the first write occurs in the cycle after the latch edge.
REQ-019 COPY: img_addr SHALL present pixel i's address; the write of pixel i (vram_addr = same address, vram_din = img_data) occurs one cycle later, pipelined, at one pixel per cycle.
REQ-020 vram_we SHALL be high exactly W*H cycles per command, where W = br_x-tl_x+1 and H = br_y-tl_y+1; the cycles are consecutive and there are no duplicate or skipped addresses.
REQ-021 DONE SHALL be entered in the cycle after the last write; finish=1 only in DONE.
REQ-022 DONE SHALL move to IDLE on the first edge with en=0; finish SHALL be low in the cycle after en is sampled low. A new command needs en to fall first.
REQ-023 en falling during FILL/COPY SHALL NOT abort; the command completes and finish is high for at least one cycle.
REQ-024 Full-screen command (0,0)-(639,479) SHALL end at address 307199 without wrap.
REQ-025 vram_addr/img_addr/vram_din SHALL hold their last value when vram_we=0.

Reset
REQ-026 rst=1 SHALL force IDLE, finish=0, vram_we=0, vram_addr=0, img_addr=0, vram_din=0 immediately, without waiting for clk.
REQ-027 rst asserted mid-command SHALL discard the command; after release, the block accepts a new command only when en is sampled high in IDLE.

Verification
REQ-028 Fill (1,1)-(2,2), arg=FFF -> writes 641, 642, 1281, 1282 on four consecutive cycles after latch; finish high in the next cycle; finish low one cycle after en drops.
REQ-029 Copy (0,0)-(1,0), ROM[a] = a[11:0] -> img_addr 0, 1 on consecutive cycles; writes (0,000) and (1,001), each one cycle later; then finish.
REQ-030 Fill with tl_x=5, br_x=4 -> no vram_we; finish high in the cycle after the latch edge.
REQ-031 Fill (630,479)-(700,500) -> 10 writes, addresses 307190..307199; clamp honoured.
REQ-032 rst pulse after the 3rd write of a 10x10 fill -> vram_we low asynchronously; after release with en still high, the command restarts from tl, with 100 writes.
REQ-033 en dropped after the 1st write of a 4-pixel fill -> all 4 writes occur; finish high for exactly one cycle; state returns to IDLE.
